// File: rtl/i2c_pkg.sv
// Shared encodings and constants for the single-byte I2C master and its benches.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WRITE, WACK, READ, RNACK, STOP, DONE
    } i2c_state_e;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } qphase_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] SLAVE1_ADDR = 7'h3C;
    localparam logic [6:0] SLAVE2_ADDR = 7'h48;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-SCL-period tick: down-counter reloading at CLK_DIV-1, pulsing qtick at terminal count.
// freeze holds the count while a slave stretches SCL; clear restarts the quarter.
module i2c_qtick_gen #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic freeze,
    output logic qtick
);

    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        qtick = 1'b0;
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = RELOAD;
        end else if (!freeze) begin
            if (cnt_q == 16'd0) begin
                qtick = 1'b1;
                cnt_d = RELOAD;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/i2c_master_fsm.sv
// Single-byte I2C master: START, address+R/W, ACK check, one byte written or read, ACK/NACK, STOP.
// Each bit spans four quarters; SCL is low only in Q0, SDA is sampled at the end of Q2.
module i2c_master_fsm
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        sda,
    inout  wire        scl
);

    i2c_state_e  state_q, state_d;
    qphase_e     phase_q, phase_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rw_q, rw_d;
    logic        ack_err_q, ack_err_d;
    logic        smp_q, smp_d;
    logic        scl_low_q, scl_low_d;
    logic        sda_low_q, sda_low_d;
    logic        sda_oe_q, sda_oe_d;
    logic        scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q;
    logic        qtick, qtick_clear, qtick_freeze;

    assign qtick_clear  = (state_q == IDLE) || (state_q == DONE);
    assign qtick_freeze = ((phase_q == Q1) || (phase_q == Q2)) && !scl_low_q && !scl_sync_q;

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk    (clk),
        .rst    (rst),
        .clear  (qtick_clear),
        .freeze (qtick_freeze),
        .qtick  (qtick)
    );

    // SDA follows SCL by one clock so data never moves on the same edge SCL falls.
    assign sda_oe_d = sda_low_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rw_d      = rw_q;
        ack_err_d = ack_err_q;
        smp_d     = smp_q;
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;

        case (state_q)
            START:                   begin sda_low_d = 1'b1; scl_low_d = (phase_q == Q1); end
            ADDR, WRITE:             begin scl_low_d = (phase_q == Q0); sda_low_d = ~shift_q[7]; end
            AACK, WACK, READ, RNACK: scl_low_d = (phase_q == Q0);
            STOP:                    begin scl_low_d = (phase_q == Q0); sda_low_d = (phase_q != Q2); end
            default: ;
        endcase

        if (state_q == IDLE) begin
            if (start) begin
                state_d   = START;
                phase_d   = Q0;
                shift_d   = addr_byte(addr, rw);
                rw_d      = rw;
                wdata_d   = wdata;
                ack_err_d = 1'b0;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (qtick) begin
            phase_d = qphase_e'(phase_q + 2'd1);
            if (phase_q == Q2) smp_d = sda_sync_q;
            case (state_q)
                START: if (phase_q == Q1) begin
                    state_d   = ADDR;
                    phase_d   = Q0;
                    bit_cnt_d = 3'd7;
                end
                ADDR, WRITE: if (phase_q == Q3) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) state_d = (state_q == ADDR) ? AACK : WACK;
                end
                AACK: if (phase_q == Q3) begin
                    if (smp_q == ACK) begin
                        state_d   = rw_q ? READ : WRITE;
                        shift_d   = wdata_q;
                        bit_cnt_d = 3'd7;
                    end else begin
                        ack_err_d = 1'b1;
                        state_d   = STOP;
                    end
                end
                WACK: if (phase_q == Q3) begin
                    if (smp_q == NACK) ack_err_d = 1'b1;
                    state_d = STOP;
                end
                READ: begin
                    if (phase_q == Q2) rdata_d = {rdata_q[6:0], sda_sync_q};
                    if (phase_q == Q3) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) state_d = RNACK;
                    end
                end
                RNACK: if (phase_q == Q3) state_d = STOP;
                STOP:  if (phase_q == Q2) state_d = DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= Q0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            wdata_q    <= 8'd0;
            rdata_q    <= 8'd0;
            rw_q       <= 1'b0;
            ack_err_q  <= 1'b0;
            smp_q      <= NACK;
            scl_low_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rw_q       <= rw_d;
            ack_err_q  <= ack_err_d;
            smp_q      <= smp_d;
            scl_low_q  <= scl_low_d;
            sda_low_q  <= sda_low_d;
            sda_oe_q   <= sda_oe_d;
            scl_meta_q <= scl;
            scl_sync_q <= scl_meta_q;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
        end
    end

    assign scl     = scl_low_q ? 1'b0 : 1'bz;
    assign sda     = sda_oe_q  ? 1'b0 : 1'bz;
    assign rdata   = rdata_q;
    assign ack_err = ack_err_q;
    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = (state_q == DONE);

endmodule

// File: doc/i2c_master_fsm.md
Name: i2c_master_fsm

Overview:
Single-byte I2C master that drives the bus against our slave FSMs and the address translator. It runs one transaction per `start` pulse: START, 7-bit address plus R/W, slave ACK check, one data byte written or read, master ACK/NACK, STOP. SCL and SDA are open-drain and are only ever driven low or released. The block is the bus initiator in system benches, and the upstream side for translator testing.

Parameters:
CLK_DIV, 250, system clocks per quarter SCL period (250 gives 100 kHz at a 100 MHz clk); legal range 2..65535.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
addr  input  7  target slave address, sent MSB first
rw  input  1  0 = write wdata, 1 = read one byte
wdata  input  8  write byte, captured with start
rdata  output  8  byte read from slave; valid when done=1 and rw=1
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at transaction end
ack_err  output  1  set with done if the address or write byte was NACKed; held until the next accepted start
sda  inout  1  open-drain data (0 or z)
scl  inout  1  open-drain clock (0 or z)

Behaviour:
- Reset (async): state IDLE; scl and sda released (z); rdata=0; busy=0; done=0; ack_err=0; tick counter and bit counter cleared. Reset mid-transaction releases both lines in the same instant; no STOP is generated.
- sda and scl inputs pass through 2-flop synchronisers before use.
- Quarter tick: a counter reloads at CLK_DIV-1 and pulses `qtick`. Each bit takes 4 quarters:
  - Q0: SCL low, drive SDA.
  - Q1: release SCL.
  - Q2: SCL high; sample SDA.
  - Q3: SCL high, then pull low at the end.
- Clock stretching: in Q1/Q2, if SCL is released but the synchronised SCL reads 0, the tick counter freezes until SCL reads 1.
- start is accepted only in IDLE. addr, rw and wdata are latched on acceptance. start while busy=1 is ignored.
- States:
  - IDLE: accepts start.
  - START: SDA low while SCL high for 1 quarter, then SCL low for 1 quarter.
  - ADDR: 8 bits {addr, rw}, MSB first; bit counter 7→0.
  - AACK: SDA released. A sampled 0 goes to WRITE (rw=0) or READ (rw=1); a sampled 1 sets ack_err and goes to STOP.
  - WRITE: 8 bits of wdata, MSB first.
  - WACK: sample 1 sets ack_err. Always goes to STOP.
  - READ: SDA released; shift the sampled bit into rdata LSB on each Q2, 8 bits.
  - RNACK: release SDA (master NACK, single byte only).
  - STOP: SCL low with SDA low for 1 quarter, release SCL for 1 quarter, release SDA for 1 quarter.
  - DONE: done=1 for one clk, busy=0, back to IDLE.
- Latency without stretching: 2 + 36 + 36 + 3 = 77 qticks from acceptance to done, plus ≤2 clk. An address NACK skips the data byte: 2 + 36 + 3 = 41 qticks.
- Arbitration loss is out of scope: a single-master bus is guaranteed.

Decomposition:
- Package i2c_pkg holds:
  - state encoding: IDLE, START, ADDR, AACK, WRITE, WACK, READ, RNACK, STOP, DONE
  - quarter-phase constants Q0..Q3
  - ACK=1'b0 and NACK=1'b1
  - default slave addresses, e.g. SLAVE2_ADDR=7'h48
- Sub-module i2c_qtick_gen holds the CLK_DIV counter with a freeze (stretch) input and the qtick output.

Test Plan:
- Write: addr=0x48, rw=0, wdata=0xA5, slave model ACKs → bus shows START, 0x90, ACK, 0xA5, ACK, STOP; done after 77 qticks; ack_err=0; slave data_in=0xA5.
- Read: addr=0x48, rw=1, slave returns 0xF0 → rdata=0xF0; master drives NACK on the 9th bit; ack_err=0.
- Address NACK: addr=0x21, no slave responds → ack_err=1; STOP directly after the address ACK slot; done after 41 qticks; no data clocks.
- Clock stretch: slave holds SCL low for 100 clk after the 3rd address bit → Q1 extended by ≥100 clk; all bits still correct; completes with ack_err=0.
- Reset mid-op: assert rst during WRITE bit 4 → scl=z and sda=z immediately, busy=0, done=0; a new write to 0x48 afterwards completes normally.
- Busy guard: pulse start again with addr=0x10 during a 0x48 transaction → ignored; bus shows only the 0x48 transaction; exactly one done pulse.
